// File: rtl/load_store_unit_pkg.sv
// Shared width codes, FSM encoding and the request legality rule for the load/store unit.
package load_store_unit_pkg;

    localparam int LSU_XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } lsu_state_e;

    // Unsigned widths only exist for loads; natural alignment is required.
    function automatic logic access_legal(input logic store, input logic [2:0] f3,
                                          input logic [1:0] off);
        logic ok;
        case (f3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = !off[0];
            F3_W:    ok = (off == 2'b00);
            F3_BU:   ok = !store;
            F3_HU:   ok = !store && !off[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Execute-side request, dcache port and writeback/fault signals of the load/store unit.
interface load_store_unit_if;
    import load_store_unit_pkg::*;

    // Handshake: a request transfers on a cycle where req_valid && req_ready;
    // upstream holds req_valid and the request fields stable until then.
    logic                req_valid;
    logic                req_ready;
    logic                req_store;
    logic [2:0]          req_funct3;
    logic [LSU_XLEN-1:0] req_addr;
    logic [LSU_XLEN-1:0] req_wdata;
    logic [4:0]          req_rd;
    logic [LSU_XLEN-1:0] dcache_addr;
    logic                dcache_re;
    logic [3:0]          dcache_we;
    logic [LSU_XLEN-1:0] dcache_din;
    logic [LSU_XLEN-1:0] dcache_dout;
    logic                stall;
    logic                ld_valid;
    logic [LSU_XLEN-1:0] ld_data;
    logic [4:0]          ld_rd;
    logic                fault;
    logic [LSU_XLEN-1:0] fault_addr;

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd,
               dcache_dout, stall,
        output req_ready, dcache_addr, dcache_re, dcache_we, dcache_din,
               ld_valid, ld_data, ld_rd, fault, fault_addr
    );

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd,
               dcache_dout, stall,
        input  req_ready, dcache_addr, dcache_re, dcache_we, dcache_din,
               ld_valid, ld_data, ld_rd, fault, fault_addr
    );

endinterface

// File: rtl/load_store_unit_load_align.sv
// Extracts the addressed byte/half/word from a dcache read word and extends it.
module load_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] dout_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  offset_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;

    always_comb begin
        shifted = dout_i >> {offset_i, 3'b000};
        case (funct3_i)
            F3_B:    data_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   data_o = {24'd0, shifted[7:0]};
            F3_H:    data_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   data_o = {16'd0, shifted[15:0]};
            default: data_o = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Registered load/store unit: captures one request, issues it to the dcache
// while honouring stall, and returns extended load data or a fault pulse.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic               clk,
    input  logic               reset,
    load_store_unit_if.slave   bus,
    output lsu_state_e         dbg_state_o
);

    lsu_state_e      state_q, state_d;
    logic            store_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [4:0]      rd_q;
    logic            fault_q;
    logic [XLEN-1:0] fault_addr_q;

    logic            accept;
    logic            legal;
    logic            issue_st;
    logic [3:0]      we_lane;
    logic [31:0]     din_lane;
    logic [31:0]     align_data;

    assign accept = bus.req_valid && (state_q == ST_IDLE);
    assign legal  = access_legal(bus.req_store, bus.req_funct3, bus.req_addr[1:0]);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept && legal) state_d = ST_ISSUE;
            ST_ISSUE: if (!bus.stall)      state_d = store_q ? ST_IDLE : ST_RESP;
            ST_RESP:  if (!bus.stall)      state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Illegal requests leave the captured transaction untouched; only the fault regs see them.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            store_q      <= 1'b0;
            funct3_q     <= 3'd0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rd_q         <= 5'd0;
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
        end else begin
            state_q <= state_d;
            fault_q <= accept && !legal;
            if (accept && legal) begin
                store_q  <= bus.req_store;
                funct3_q <= bus.req_funct3;
                addr_q   <= bus.req_addr;
                wdata_q  <= bus.req_wdata;
                rd_q     <= bus.req_rd;
            end
            if (accept && !legal) fault_addr_q <= bus.req_addr;
        end
    end

    always_comb begin
        we_lane  = 4'b1111;
        din_lane = wdata_q;
        case (funct3_q[1:0])
            2'b00: begin
                we_lane  = 4'b0001 << addr_q[1:0];
                din_lane = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                we_lane  = 4'b0011 << addr_q[1:0];
                din_lane = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    load_align u_load_align (
        .dout_i   (bus.dcache_dout),
        .funct3_i (funct3_q),
        .offset_i (addr_q[1:0]),
        .data_o   (align_data)
    );

    assign issue_st        = (state_q == ST_ISSUE) && store_q;
    assign bus.req_ready   = (state_q == ST_IDLE);
    assign bus.dcache_addr = {addr_q[XLEN-1:2], 2'b00};
    assign bus.dcache_re   = (state_q == ST_ISSUE) && !store_q;
    assign bus.dcache_we   = issue_st ? we_lane : 4'b0000;
    assign bus.dcache_din  = issue_st ? din_lane : '0;
    assign bus.ld_valid    = (state_q == ST_RESP) && !bus.stall;
    assign bus.ld_data     = bus.ld_valid ? align_data : '0;
    assign bus.ld_rd       = rd_q;
    assign bus.fault       = fault_q;
    assign bus.fault_addr  = fault_addr_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: reset, table vectors, randomized transactions
// against a byte-level reference model, and stall/reset corner sequences.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    load_store_unit_if bus();
    lsu_state_e dbg_state;

    load_store_unit #(.XLEN(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] dout;
        logic [4:0]  rd;
        logic        exp_fault;
        logic [3:0]  exp_we;
        logic [31:0] exp_din;
        logic [31:0] exp_data;
    } vec_t;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_fault_addr = 32'd0;
    vec_t tbl[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: byte-granular view of the access rules.
    function automatic int acc_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit model_legal(input logic st, input logic [2:0] f3, input logic [31:0] addr);
        bit code_ok;
        code_ok = st ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        return code_ok && ((int'(addr[1:0]) % acc_size(f3)) == 0);
    endfunction

    function automatic logic [3:0] model_we(input logic [2:0] f3, input logic [31:0] addr);
        logic [3:0] we = 4'b0000;
        for (int i = 0; i < acc_size(f3); i++) we[int'(addr[1:0]) + i] = 1'b1;
        return we;
    endfunction

    function automatic logic [31:0] model_din(input logic [2:0] f3, input logic [31:0] wdata);
        logic [31:0] din;
        for (int b = 0; b < 4; b++) din[8*b +: 8] = wdata[8*(b % acc_size(f3)) +: 8];
        return din;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] dout);
        logic [31:0] val = 32'd0;
        int sz = acc_size(f3);
        for (int i = 0; i < sz; i++) val[8*i +: 8] = dout[8*(int'(addr[1:0]) + i) +: 8];
        if (!f3[2] && sz < 4 && val[8*sz-1])
            for (int j = 8*sz; j < 32; j++) val[j] = 1'b1;
        return val;
    endfunction

    task automatic run_txn(input vec_t v, input int s_issue, input int s_resp, input string tag);
        int guard = 0;
        @(negedge clk);
        while (!bus.req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.req_ready) begin
            check({tag, " ready_timeout"}, 32'd0, 32'd1);
            return;
        end
        bus.req_valid   = 1'b1;
        bus.req_store   = v.st;
        bus.req_funct3  = v.f3;
        bus.req_addr    = v.addr;
        bus.req_wdata   = v.wdata;
        bus.req_rd      = v.rd;
        bus.dcache_dout = v.dout;
        bus.stall       = 1'b0;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.stall     = (s_issue > 0);
        if (v.exp_fault) begin
            @(negedge clk);
            check({tag, " fault"}, {31'd0, bus.fault}, 32'd1);
            check({tag, " fault_addr"}, bus.fault_addr, v.addr);
            check({tag, " no_strobe"}, {27'd0, bus.dcache_re, bus.dcache_we}, 32'd0);
            check({tag, " state_idle"}, {30'd0, dbg_state}, {30'd0, ST_IDLE});
            exp_fault_addr = v.addr;
            @(negedge clk);
            check({tag, " fault_pulse_end"}, {31'd0, bus.fault}, 32'd0);
            return;
        end
        for (int k = 0; k <= s_issue; k++) begin
            @(negedge clk);
            check({tag, " re"}, {31'd0, bus.dcache_re}, {31'd0, !v.st});
            check({tag, " we"}, {28'd0, bus.dcache_we}, {28'd0, v.st ? v.exp_we : 4'b0000});
            check({tag, " din"}, bus.dcache_din, v.st ? v.exp_din : 32'd0);
            check({tag, " addr"}, bus.dcache_addr, {v.addr[31:2], 2'b00});
            check({tag, " issue_no_ldv"}, {31'd0, bus.ld_valid}, 32'd0);
            @(posedge clk);
            #1;
            bus.stall = (k + 1 < s_issue);
        end
        if (!v.st) begin
            exp_q.push_back(v.exp_data);
            bus.stall = (s_resp > 0);
            for (int k = 0; k <= s_resp; k++) begin
                @(negedge clk);
                check({tag, " resp_strobes"}, {27'd0, bus.dcache_re, bus.dcache_we}, 32'd0);
                if (k < s_resp) begin
                    check({tag, " ldv_stalled"}, {31'd0, bus.ld_valid}, 32'd0);
                end else begin
                    check({tag, " ldv"}, {31'd0, bus.ld_valid}, 32'd1);
                    if (exp_q.size() > 0) check({tag, " ld_data"}, bus.ld_data, exp_q.pop_front());
                    check({tag, " ld_rd"}, {27'd0, bus.ld_rd}, {27'd0, v.rd});
                end
                @(posedge clk);
                #1;
                bus.stall = (k + 1 < s_resp);
            end
        end
        @(negedge clk);
        check({tag, " ready_back"}, {31'd0, bus.req_ready}, 32'd1);
        check({tag, " idle_quiet"}, {26'd0, bus.ld_valid, bus.fault, bus.dcache_we}, 32'd0);
        check({tag, " fault_addr_hold"}, bus.fault_addr, exp_fault_addr);
    endtask

    initial begin
        vec_t v;
        int re_cnt, lv_cnt, lat;

        //     st    f3    addr          wdata         dout          rd    flt   we       din           data
        tbl[0]  = '{1'b1, F3_W,  32'h100, 32'hDEADBEEF, 32'h0,        5'd0,  1'b0, 4'b1111, 32'hDEADBEEF, 32'h0};
        tbl[1]  = '{1'b1, F3_B,  32'h103, 32'h000000A5, 32'h0,        5'd0,  1'b0, 4'b1000, 32'hA5A5A5A5, 32'h0};
        tbl[2]  = '{1'b1, F3_H,  32'h102, 32'h00001234, 32'h0,        5'd0,  1'b0, 4'b1100, 32'h12341234, 32'h0};
        tbl[3]  = '{1'b0, F3_B,  32'h102, 32'h0,        32'h0080FF00, 5'd3,  1'b0, 4'b0000, 32'h0,        32'hFFFFFF80};
        tbl[4]  = '{1'b0, F3_BU, 32'h102, 32'h0,        32'h0080FF00, 5'd4,  1'b0, 4'b0000, 32'h0,        32'h00000080};
        tbl[5]  = '{1'b0, F3_HU, 32'h102, 32'h0,        32'h0080FF00, 5'd5,  1'b0, 4'b0000, 32'h0,        32'h00000080};
        tbl[6]  = '{1'b0, F3_H,  32'h100, 32'h0,        32'h0000FF00, 5'd6,  1'b0, 4'b0000, 32'h0,        32'hFFFFFF00};
        tbl[7]  = '{1'b0, F3_W,  32'h204, 32'h0,        32'h12345678, 5'd31, 1'b0, 4'b0000, 32'h0,        32'h12345678};
        tbl[8]  = '{1'b0, F3_H,  32'h101, 32'h0,        32'h0,        5'd7,  1'b1, 4'b0000, 32'h0,        32'h0};
        tbl[9]  = '{1'b0, 3'b011, 32'h100, 32'h0,       32'h0,        5'd8,  1'b1, 4'b0000, 32'h0,        32'h0};
        tbl[10] = '{1'b1, F3_W,  32'h102, 32'h11111111, 32'h0,        5'd0,  1'b1, 4'b0000, 32'h0,        32'h0};
        tbl[11] = '{1'b1, F3_BU, 32'h104, 32'h22222222, 32'h0,        5'd0,  1'b1, 4'b0000, 32'h0,        32'h0};

        reset           = 1'b1;
        bus.req_valid   = 1'b0;
        bus.req_store   = 1'b0;
        bus.req_funct3  = 3'd0;
        bus.req_addr    = 32'd0;
        bus.req_wdata   = 32'd0;
        bus.req_rd      = 5'd0;
        bus.dcache_dout = 32'd0;
        bus.stall       = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        check("rst ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst strobes", {27'd0, bus.dcache_re, bus.dcache_we}, 32'd0);
        check("rst addr", bus.dcache_addr, 32'd0);
        check("rst din", bus.dcache_din, 32'd0);
        check("rst ld", {26'd0, bus.ld_valid, bus.ld_rd}, 32'd0);
        check("rst ld_data", bus.ld_data, 32'd0);
        check("rst fault", {31'd0, bus.fault}, 32'd0);
        check("rst fault_addr", bus.fault_addr, 32'd0);

        for (int i = 0; i < 12; i++) run_txn(tbl[i], 0, 0, $sformatf("vec%0d", i));

        // Randomized traffic with stalls, expectations from the model.
        for (int i = 0; i < 60; i++) begin
            v.st       = 1'($urandom_range(0, 1));
            v.f3       = 3'($urandom_range(0, 7));
            v.addr     = $urandom;
            v.wdata    = $urandom;
            v.dout     = $urandom;
            v.rd       = 5'($urandom_range(0, 31));
            v.exp_fault = !model_legal(v.st, v.f3, v.addr);
            v.exp_we   = v.st ? model_we(v.f3, v.addr) : 4'b0000;
            v.exp_din  = v.st ? model_din(v.f3, v.wdata) : 32'd0;
            v.exp_data = model_load(v.f3, v.addr, v.dout);
            run_txn(v, $urandom_range(0, 2), $urandom_range(0, 2), $sformatf("rnd%0d", i));
        end

        // LW with 3 stall cycles in ISSUE and 2 in RESP.
        @(negedge clk);
        bus.req_valid   = 1'b1;
        bus.req_store   = 1'b0;
        bus.req_funct3  = F3_W;
        bus.req_addr    = 32'h200;
        bus.req_rd      = 5'd17;
        bus.dcache_dout = 32'hCAFEF00D;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        re_cnt = 0;
        lv_cnt = 0;
        lat    = 0;
        for (int c = 1; c <= 12; c++) begin
            bus.stall = (c <= 3) || (c == 5) || (c == 6);
            @(negedge clk);
            if (bus.dcache_re) begin
                re_cnt++;
                check("stall re_addr", bus.dcache_addr, 32'h200);
            end
            if (bus.ld_valid) begin
                lv_cnt++;
                lat = c;
                check("stall ld_data", bus.ld_data, 32'hCAFEF00D);
                check("stall ld_rd", {27'd0, bus.ld_rd}, 32'd17);
            end
            @(posedge clk);
            #1;
        end
        bus.stall = 1'b0;
        check("stall re_cycles", re_cnt, 32'd4);
        check("stall ldv_count", lv_cnt, 32'd1);
        check("stall latency", lat, 32'd7);

        // Reset while waiting in RESP under stall.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h300;
        bus.req_rd    = 5'd9;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        #1 bus.stall = 1'b1;
        @(negedge clk);
        check("rr in_resp", {30'd0, dbg_state}, {30'd0, ST_RESP});
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        exp_fault_addr = 32'd0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rr state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
            check("rr ldv", {31'd0, bus.ld_valid}, 32'd0);
            check("rr strobes", {27'd0, bus.dcache_re, bus.dcache_we}, 32'd0);
            check("rr addr", bus.dcache_addr, 32'd0);
            check("rr ld_rd", {27'd0, bus.ld_rd}, 32'd0);
            check("rr fault_addr", bus.fault_addr, 32'd0);
        end
        bus.stall = 1'b0;

        v = tbl[0];
        run_txn(v, 1, 0, "post_reset_sw");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Registered load/store unit sitting between the execute stage and the data cache port of the 3-stage Riscv151 core. Accepts one memory request per transaction from execute, generates word-aligned dcache address, byte-enables and shifted store data, holds everything frozen while `stall` is high, then returns sign/zero-extended load data to writeback. Misaligned or illegal-width accesses are never issued to memory; they raise a one-cycle fault pulse instead.

## Interface

Parameters:
- `XLEN`, 32: data/address width; only 32 is supported.

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; one clock, one reset, both fixed.
- `req_valid`  in  1  execute presents a memory op this cycle.
- `req_ready`  out  1  high only in IDLE; a request is accepted when `req_valid && req_ready`.
- `req_store`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I load/store width code.
- `req_addr`  in  32  effective address (ALU result).
- `req_wdata`  in  32  rs2 value for stores.
- `req_rd`  in  5  load destination register.
- `dcache_addr`  out  32  `{addr[31:2],2'b00}` of the captured request.
- `dcache_re`  out  1  load read strobe.
- `dcache_we`  out  4  store byte enables.
- `dcache_din`  out  32  lane-shifted store data.
- `dcache_dout`  in  32  read data, valid the cycle after an accepted read.
- `stall`  in  1  memory system not ready; freezes the unit.
- `ld_valid`  out  1  one-cycle pulse: `ld_data`/`ld_rd` valid.
- `ld_data`  out  32  extended load result.
- `ld_rd`  out  5  destination register of the returned load.
- `fault`  out  1  one-cycle pulse: misaligned or illegal request rejected.
- `fault_addr`  out  32  `req_addr` of the rejected request; holds until next fault.

## Operation

- States: IDLE, ISSUE, RESP. Reset -> IDLE.
- IDLE: on accept, capture store flag, funct3, addr, wdata, rd. Legal -> ISSUE. Illegal -> stay IDLE, `fault`=1 next cycle, `fault_addr` updated.
- Legality: funct3 ∈ {000,001,010,100,101} for loads, {000,001,010} for stores; halfword requires addr[0]=0; word requires addr[1:0]=00. Anything else is illegal.
- ISSUE: drive `dcache_addr`; load -> `dcache_re`=1; store -> `dcache_we`, `dcache_din`. If `stall`=1 stay ISSUE, outputs unchanged. If `stall`=0: store -> IDLE; load -> RESP.
- RESP: `dcache_re`=0, `dcache_we`=0, `dcache_addr` held. If `stall`=0 sample `dcache_dout`, pulse `ld_valid` with extended data, -> IDLE. If `stall`=1 stay RESP, `ld_valid`=0.
- Store lanes, off = addr[1:0]: SB we=`0001<<off`, din=`{4{wdata[7:0]}}`; SH we=`0011<<off`, din=`{2{wdata[15:0]}}`; SW we=`1111`, din=wdata.
- Load extract: shifted = dout >> (8*off); LB sign-extend bit 7, LBU zero-extend byte, LH sign-extend bit 15, LHU zero-extend half, LW whole word.
- `ld_valid` and `fault` are never high in the same cycle.

## Timing

- Reset values: state IDLE, `req_ready`=1, `dcache_re`=0, `dcache_we`=0, `dcache_addr`=0, `dcache_din`=0, `ld_valid`=0, `ld_data`=0, `ld_rd`=0, `fault`=0, `fault_addr`=0.
- Store, no stall: accept N, write strobe N+1, `req_ready` high N+2.
- Load, no stall: accept N, `dcache_re` N+1, `ld_valid` N+2, `req_ready` high N+3.
- Each stall cycle adds exactly one cycle in the stalled state; no strobe is repeated-with-change or dropped.
- `ld_valid` is combinational from RESP && !stall; `ld_data` is combinational extraction of `dcache_dout` in that cycle.
- Reset mid-ISSUE/RESP: transaction abandoned; strobes low and no `ld_valid` from the cycle after the reset edge.
- `req_valid` while not ready is ignored; upstream must hold it.

## Structure

- Width codes (LB..LHU, SB..SW) and state encoding go in `const.vh` alongside existing core constants.
- One combinational sub-module `load_align` (dout, funct3, offset -> extended data); FSM, capture registers and store-lane logic stay in `load_store_unit`.

## Test plan

- SW addr 0x100, wdata 0xDEADBEEF, no stall -> N+1: addr 0x100, we=1111, din 0xDEADBEEF; ready at N+2.
- SB addr 0x103, wdata 0x000000A5 -> we=1000, din 0xA5A5A5A5, addr 0x100.
- LB addr 0x102, dout 0x0080FF00 -> ld_data 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x102 -> 0x00000080; LH addr 0x100 dout 0x0000FF00 -> 0xFFFFFF00.
- LW addr 0x200 with stall high 3 cycles in ISSUE and 2 in RESP -> re held 4 cycles, single ld_valid with correct rd, total latency 7.
- LH addr 0x101 and funct3=011 -> no dcache strobe, fault pulse, fault_addr 0x101 then updated; state stays IDLE.
- Reset asserted during RESP with stall high -> next cycle IDLE, ld_valid never pulses, all outputs at reset values.
